// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the parametrised priority encoder: mode encodings
// and a ceiling-log2 helper used to size the encoded index.
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Never returns less than 1 so an index port always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_core.sv
// Combinational N-input encoder: picks the first set bit searching downward
// from i_start (wrapping N-1 after 0), plus none/multi flags on the raw vector.
module prio_enc_core
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic [W-1:0] o_idx,
    output logic         o_none,
    output logic         o_multi
);

    logic [N-1:0] w_rot;
    logic [W-1:0] w_pos;
    logic         w_hit;
    logic [W:0]   w_count;

    // Maps rotated position j back to an original index: (base + 1 + j) mod N.
    // Both operands are below N, so a single conditional subtract is enough.
    function automatic logic [W-1:0] wrap_index(input logic [W-1:0] base, input int off);
        int sum;
        sum = int'(base) + 1 + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return W'(sum);
    endfunction

    // Rotation puts i_start at the top, so a plain highest-bit search does the job.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = i_req[wrap_index(i_start, j)];
        end
    end

    // NOTE: every variable gets a default before the loop; without it an
    // all-zero vector would leave w_pos unassigned and infer a latch.
    always_comb begin
        w_hit   = 1'b0;
        w_pos   = '0;
        w_count = '0;
        for (int j = 0; j < N; j++) begin
            if (w_rot[j]) begin
                w_hit = 1'b1;
                w_pos = W'(j);
            end
            if (i_req[j]) begin
                w_count = w_count + (W+1)'(1);
            end
        end
    end

    assign o_idx   = w_hit ? wrap_index(i_start, int'(w_pos)) : '0;
    assign o_none  = ~w_hit;
    assign o_multi = (w_count >= (W+1)'(2));

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N:log2(N) priority encoder with valid/ready handshake and
// run-time selectable fixed (highest index wins) or round-robin priority.
module prio_encoder_rr
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         rr_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_multi
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic [W-1:0] r_rr_ptr;
    logic [W-1:0] r_idx;
    logic         r_valid;
    logic         r_none;
    logic         r_multi;

    logic [W-1:0] w_start;
    logic [W-1:0] w_idx;
    logic         w_none;
    logic         w_multi;
    logic         w_in_ready;
    logic         w_in_fire;

    // Round-robin searches from just below the last grant; fixed mode always
    // starts at the top, which reduces to a plain highest-index encoder.
    assign w_start = (rr_mode == MODE_RR)
                   ? ((r_rr_ptr == '0) ? LAST_IDX : (r_rr_ptr - W'(1)))
                   : LAST_IDX;

    assign w_in_ready = en & (~r_valid | out_ready);
    assign w_in_fire  = in_valid & w_in_ready;

    prio_enc_core #(
        .N (N)
    ) u_core (
        .i_req   (in_req),
        .i_start (w_start),
        .o_idx   (w_idx),
        .o_none  (w_none),
        .o_multi (w_multi)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order in this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_none   <= 1'b0;
            r_multi  <= 1'b0;
            r_rr_ptr <= LAST_IDX;
        end else begin
            if (w_in_fire) begin
                r_valid <= 1'b1;
                r_idx   <= w_idx;
                r_none  <= w_none;
                r_multi <= w_multi;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            // An empty vector grants nothing, so the rotation must not move.
            if (w_in_fire && (rr_mode == MODE_RR) && !w_none) begin
                r_rr_ptr <= w_idx;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_none  = r_none;
    assign out_multi = r_multi;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench: an N=8 and an N=5 instance checked every cycle against
// a behavioural model, plus directed sequences with hand-computed results.
module tb_prio_encoder_rr;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Index 0 drives the N=8 instance, index 1 the N=5 instance.
    logic [1:0]      s_en, s_rr, s_valid, s_ordy;
    logic [1:0][7:0] s_req;
    logic [1:0]      o_rdy, o_valid, o_none, o_multi;
    logic [1:0][2:0] o_idx;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    bit m_valid [2];
    int m_idx   [2];
    bit m_none  [2];
    bit m_multi [2];
    int m_ptr   [2];

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (s_en[0]),
        .rr_mode   (s_rr[0]),
        .in_valid  (s_valid[0]),
        .in_ready  (o_rdy[0]),
        .in_req    (s_req[0]),
        .out_valid (o_valid[0]),
        .out_ready (s_ordy[0]),
        .out_idx   (o_idx[0]),
        .out_none  (o_none[0]),
        .out_multi (o_multi[0])
    );

    prio_encoder_rr #(.N(5)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (s_en[1]),
        .rr_mode   (s_rr[1]),
        .in_valid  (s_valid[1]),
        .in_ready  (o_rdy[1]),
        .in_req    (s_req[1][4:0]),
        .out_valid (o_valid[1]),
        .out_ready (s_ordy[1]),
        .out_idx   (o_idx[1]),
        .out_none  (o_none[1]),
        .out_multi (o_multi[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Grant straight from the rule: fixed = highest set index; round-robin =
    // first set index among ptr-1, ptr-2, ... (mod n).
    function automatic int grant(input logic [7:0] req, input int n, input int ptr, input bit rr);
        int g;
        int i;
        g = 0;
        if (!rr) begin
            for (int k = 0; k < n; k++) if (req[k]) g = k;
        end else begin
            for (int k = n; k >= 1; k--) begin
                i = (ptr - k + n) % n;
                if (req[i]) g = i;
            end
        end
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 0; m_idx[d] = 0; m_none[d] = 0; m_multi[d] = 0;
                m_ptr[d]   = (d == 0) ? 7 : 4;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int          n;
                logic [7:0]  req;
                bit          rdy;
                n   = (d == 0) ? 8 : 5;
                req = s_req[d] & ((d == 0) ? 8'hFF : 8'h1F);
                rdy = s_en[d] && (!m_valid[d] || s_ordy[d]);
                if (s_valid[d] && rdy) begin
                    m_valid[d] = 1;
                    m_none[d]  = (req == 0);
                    m_multi[d] = ($countones(req) >= 2);
                    m_idx[d]   = m_none[d] ? 0 : grant(req, n, m_ptr[d], s_rr[d]);
                    if (s_rr[d] && !m_none[d]) m_ptr[d] = m_idx[d];
                end else if (s_ordy[d]) begin
                    m_valid[d] = 0;
                end
            end
        end
    end

    // Compare process: outputs are stable on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("in_ready[%0d]", d),  32'(o_rdy[d]),
                  32'(s_en[d] && (!m_valid[d] || s_ordy[d])));
            check($sformatf("out_valid[%0d]", d), 32'(o_valid[d]), 32'(m_valid[d]));
            check($sformatf("out_idx[%0d]", d),   32'(o_idx[d]),   32'(m_idx[d]));
            check($sformatf("out_none[%0d]", d),  32'(o_none[d]),  32'(m_none[d]));
            check($sformatf("out_multi[%0d]", d), 32'(o_multi[d]), 32'(m_multi[d]));
        end
    end

    // One accepted transfer; result must be visible one cycle later.
    task automatic send(input int d, input logic [7:0] req, input int exp_idx,
                        input bit exp_none, input bit exp_multi);
        s_valid[d] = 1'b1;
        s_req[d]   = req;
        @(posedge clk); #1;
        s_valid[d] = 1'b0;
        check($sformatf("send_valid[%0d]", d), 32'(o_valid[d]), 32'd1);
        check($sformatf("send_idx[%0d] req=%h", d, req), 32'(o_idx[d]), 32'(exp_idx));
        check($sformatf("send_none[%0d]", d),  32'(o_none[d]),  32'(exp_none));
        check($sformatf("send_multi[%0d]", d), 32'(o_multi[d]), 32'(exp_multi));
    endtask

    initial begin
        logic [7:0] v;
        s_en = '1; s_rr = '0; s_valid = '0; s_ordy = '1; s_req = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_valid[%0d]", d), 32'(o_valid[d]), 32'd0);
            check($sformatf("reset_idx[%0d]", d),   32'(o_idx[d]),   32'd0);
        end
        rst_n = 1'b1;

        // Fixed mode one-hot sweep, mixed vector and zero vector.
        for (int i = 0; i < 8; i++) begin
            v = 8'd1 << i;
            send(0, v, i, 0, 0);
        end
        send(0, 8'b1010_0100, 7, 0, 1);
        send(0, 8'h00, 0, 1, 0);
        send(1, 8'b0001_0110, 4, 0, 1);

        // Round-robin alternation, then a full descending rotation from ptr=0.
        s_rr[0] = 1'b1;
        send(0, 8'b0001_0010, 4, 0, 1);
        send(0, 8'b0001_0010, 1, 0, 1);
        send(0, 8'b0001_0010, 4, 0, 1);
        send(0, 8'b0001_0010, 1, 0, 1);
        send(0, 8'h01, 0, 0, 0);
        for (int k = 0; k < 9; k++) send(0, 8'hFF, (15 - k) % 8, 0, 1);

        // Backpressure: result held while the consumer stalls.
        s_rr[0] = 1'b0;
        send(0, 8'h40, 6, 0, 0);
        s_ordy[0] = 1'b0; s_valid[0] = 1'b1; s_req[0] = 8'h03;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", 32'(o_rdy[0]), 32'd0);
            @(posedge clk); #1;
            check("bp_idx_held", 32'(o_idx[0]), 32'd6);
            check("bp_valid_held", 32'(o_valid[0]), 32'd1);
        end
        s_ordy[0] = 1'b1;
        send(0, 8'h03, 1, 0, 1);
        send(0, 8'h10, 4, 0, 0);
        send(0, 8'h08, 3, 0, 0);

        // Mid-run reset with a result pending.
        s_rr[0] = 1'b1;
        s_ordy[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid[0]), 32'd0);
        check("midrst_idx",   32'(o_idx[0]),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_ordy[0] = 1'b1;
        send(0, 8'hFF, 6, 0, 1);

        // Enable low: no accept, pointer frozen, output still drains.
        s_en[0] = 1'b0; s_valid[0] = 1'b1; s_req[0] = 8'hFF;
        #1;
        check("en0_in_ready", 32'(o_rdy[0]), 32'd0);
        @(posedge clk); #1;
        check("en0_drained", 32'(o_valid[0]), 32'd0);
        @(posedge clk); #1;
        s_en[0] = 1'b1;
        send(0, 8'hFF, 5, 0, 1);

        // Non-power-of-two build: N=5 rotation.
        s_rr[1] = 1'b1;
        send(1, 8'h01, 0, 0, 0);
        for (int k = 0; k < 6; k++) send(1, 8'h1F, (9 - k) % 5, 0, 1);

        // Randomised traffic on both instances, occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 499) != 0);
            for (int d = 0; d < 2; d++) begin
                s_en[d]    = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 15) == 0) s_rr[d] = ~s_rr[d];
                s_valid[d] = ($urandom_range(0, 3) != 0);
                s_ordy[d]  = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       v = 8'h00;
                    1:       v = 8'd1 << $urandom_range(0, 7);
                    default: v = 8'($urandom);
                endcase
                s_req[d] = (d == 0) ? v : (v & 8'h1F);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
